// File: rtl/execute_fw_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// execute_fw_if : ID/EX, MEM/WB and EX/MEM signal bundle of the execute stage | rev 1.0
//----------------------------------------------------------------------------
interface execute_fw_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      valid_in;
    logic [3:0]                op;
    logic                      alu_src;
    logic [DATA_WIDTH-1:0]     registro_1;
    logic [DATA_WIDTH-1:0]     registro_2;
    logic [DATA_WIDTH-1:0]     sign_extend;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write_in;
    logic [REG_ADDR_WIDTH-1:0] mem_wb_rd;
    logic                      mem_wb_reg_write;
    logic [DATA_WIDTH-1:0]     mem_wb_data;
    logic                      flush;
    logic                      stall;
    logic                      valid_out;
    logic [DATA_WIDTH-1:0]     result;
    logic [DATA_WIDTH-1:0]     registro_2_out;
    logic [REG_ADDR_WIDTH-1:0] rd_out;
    logic                      reg_write_out;

    modport slave (
        input  valid_in, op, alu_src, registro_1, registro_2, sign_extend,
               rs, rt, rd, reg_write_in, mem_wb_rd, mem_wb_reg_write,
               mem_wb_data, flush,
        output stall, valid_out, result, registro_2_out, rd_out, reg_write_out
    );

    modport master (
        output valid_in, op, alu_src, registro_1, registro_2, sign_extend,
               rs, rt, rd, reg_write_in, mem_wb_rd, mem_wb_reg_write,
               mem_wb_data, flush,
        input  stall, valid_out, result, registro_2_out, rd_out, reg_write_out
    );
endinterface
`default_nettype wire

// File: rtl/execute_fw.sv
`default_nettype none
//----------------------------------------------------------------------------
// execute_fw : forwarding execute stage, EX/MEM register, shift-add MUL | rev 1.0
//----------------------------------------------------------------------------
module execute_fw #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    execute_fw_if.slave  bus
);
    localparam int c_shamt_w = $clog2(DATA_WIDTH);
    localparam logic [c_shamt_w-1:0] c_cnt_last = c_shamt_w'(DATA_WIDTH - 1);

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_xor = 4'd4;
    localparam logic [3:0] c_op_nor = 4'd5;
    localparam logic [3:0] c_op_slt = 4'd6;
    localparam logic [3:0] c_op_sll = 4'd7;
    localparam logic [3:0] c_op_srl = 4'd8;
    localparam logic [3:0] c_op_sra = 4'd9;
    localparam logic [3:0] c_op_mul = 4'd10;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t                    r_state, w_state_next;
    logic                      w_stall, w_mul_start, w_mul_done;
    logic                      r_valid, r_reg_write;
    logic [DATA_WIDTH-1:0]     r_result, r_rs2;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_mcand, r_mplier, r_acc;
    logic [c_shamt_w-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]     w_fwd_a, w_fwd_b, w_op2, w_alu, w_acc_next;
    logic [c_shamt_w-1:0]      w_shamt;
    logic                      w_lt;

    // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
    always_comb begin
        w_fwd_a = bus.registro_1;
        if (r_valid && r_reg_write && r_rd != '0 && r_rd == bus.rs)
            w_fwd_a = r_result;
        else if (bus.mem_wb_reg_write && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.rs)
            w_fwd_a = bus.mem_wb_data;

        w_fwd_b = bus.registro_2;
        if (r_valid && r_reg_write && r_rd != '0 && r_rd == bus.rt)
            w_fwd_b = r_result;
        else if (bus.mem_wb_reg_write && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.rt)
            w_fwd_b = bus.mem_wb_data;
    end

    assign w_op2   = bus.alu_src ? bus.sign_extend : w_fwd_b;
    assign w_shamt = w_op2[c_shamt_w-1:0];
    assign w_lt    = $signed(w_fwd_a) < $signed(w_op2);

    always_comb begin
        w_alu = '0;
        case (bus.op)
            c_op_add: w_alu = w_fwd_a + w_op2;
            c_op_sub: w_alu = w_fwd_a - w_op2;
            c_op_and: w_alu = w_fwd_a & w_op2;
            c_op_or:  w_alu = w_fwd_a | w_op2;
            c_op_xor: w_alu = w_fwd_a ^ w_op2;
            c_op_nor: w_alu = ~(w_fwd_a | w_op2);
            c_op_slt: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            c_op_sll: w_alu = w_fwd_a << w_shamt;
            c_op_srl: w_alu = w_fwd_a >> w_shamt;
            c_op_sra: w_alu = $signed(w_fwd_a) >>> w_shamt;
            default:  w_alu = '0;
        endcase
    end

    // One partial product per BUSY edge; the last one is folded in at release.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.valid_in && bus.op == c_op_mul) begin
                    w_stall      = 1'b1;
                    w_mul_start  = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == c_cnt_last) begin
                    w_mul_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (bus.flush) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (bus.flush || w_mul_done) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= w_fwd_a;
            r_mplier <= w_op2;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_result    <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
        end else if (bus.flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (w_mul_done) begin
            r_valid     <= 1'b1;
            r_reg_write <= bus.reg_write_in;
            r_result    <= w_acc_next;
            r_rs2       <= w_fwd_b;
            r_rd        <= bus.rd;
        end else if (w_mul_start || r_state == ST_BUSY) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else begin
            r_valid     <= bus.valid_in;
            r_reg_write <= bus.valid_in && bus.reg_write_in;
            r_result    <= w_alu;
            r_rs2       <= w_fwd_b;
            r_rd        <= bus.rd;
        end
    end

    assign bus.stall          = w_stall;
    assign bus.valid_out      = r_valid;
    assign bus.reg_write_out  = r_reg_write;
    assign bus.result         = r_result;
    assign bus.registro_2_out = r_rs2;
    assign bus.rd_out         = r_rd;
endmodule
`default_nettype wire

// File: doc/execute_fw.md
Name: execute_fw

Overview:
Parametrised execute stage with its own EX/MEM pipeline register.
- Resolves RAW hazards by forwarding from its own EX/MEM output and from the MEM/WB stage.
- Selects register or immediate for the second operand, executes ALU ops in a single cycle.
- Executes MUL over multiple cycles with an upstream stall handshake.
- Sits between the ID/EX register and the memory stage.

Parameters:
DATA_WIDTH, 32, datapath width W (>=8, power of two); shift amount uses the low log2(W) bits of operand 2
REG_ADDR_WIDTH, 5, register-index width A

Ports:
clock  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  ID/EX slot holds a live instruction
op  in  4  operation code
alu_src  in  1  1 = operand 2 is sign_extend, 0 = forwarded rt value
registro_1  in  W  rs value read in ID
registro_2  in  W  rt value read in ID
sign_extend  in  W  extended immediate
rs  in  A  source index 1
rt  in  A  source index 2
rd  in  A  destination index
reg_write_in  in  1  instruction writes rd
mem_wb_rd  in  A  MEM/WB destination index
mem_wb_reg_write  in  1  MEM/WB writes its rd
mem_wb_data  in  W  MEM/WB write-back value
flush  in  1  synchronous kill of this stage
stall  out  1  upstream must hold ID/EX contents this cycle
valid_out  out  1  EX/MEM slot holds a live instruction
result  out  W  EX/MEM ALU result
registro_2_out  out  W  EX/MEM forwarded rt value (store data)
rd_out  out  A  EX/MEM destination index
reg_write_out  out  1  EX/MEM write enable

Behaviour:
- Reset (async, reset_n=0): valid_out, result, registro_2_out, rd_out, reg_write_out and the multiplier accumulator and counter all clear to 0. FSM goes to IDLE and stall is 0.
- Forwarding: applies per source, to rs and to rt independently.
  - Priority 1 is EX/MEM: valid_out & reg_write_out & rd_out!=0 & rd_out==index gives result.
  - Priority 2 is MEM/WB: mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==index gives mem_wb_data.
  - Otherwise the registro_x input is used.
  - Index 0 is never forwarded.
- Operand 2 is sign_extend if alu_src=1, otherwise forwarded rt. registro_2_out always captures forwarded rt.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 1/0).
  - 7 SLL, 8 SRL, 9 SRA.
  - 10 MUL, returning the low W bits of the unsigned product.
  - 11-15 give result 0.
  - All arithmetic is modulo 2^W. Overflow is ignored.
- Single-cycle ops: inputs in cycle N appear in EX/MEM after edge N (latency 1). stall stays 0.
- MUL FSM (states IDLE, BUSY):
  - IDLE: if valid_in & op==10, stall=1 combinationally. At the edge, the forwarded operands are latched, cnt=0, the state goes to BUSY, and EX/MEM is written as a bubble (valid_out=0, reg_write_out=0).
  - BUSY: one shift-add step per edge, cnt++. stall=1 while cnt<W-1.
  - When cnt==W-1, stall=0. At that edge the final product goes to EX/MEM with valid_out=1, and the state returns to IDLE.
  - ID/EX advances on that same edge.
  - A MUL occupies W+1 cycles, with stall high for exactly W cycles.
- valid_in=0 in IDLE: at the edge, valid_out=0 and reg_write_out=0. The data fields are don't-care.
- flush=1: has priority over everything, including an in-progress MUL.
  - At the edge: valid_out=0, reg_write_out=0, FSM to IDLE, cnt=0.
  - stall drops the cycle after the flush.
- Back-to-back MUL: the second MUL is accepted in the cycle after the first completes, when IDLE is re-entered. It forwards the first MUL's product from EX/MEM.
- Reset asserted mid-MUL: aborts immediately. No partial result is ever output.

Test Plan:
- W=32. ADD r3=r1+r2 with r1=5, r2=7, no hazards -> one edge later result=12, rd_out=3, valid_out=1, reg_write_out=1, stall never high.
- ADD r3 then SUB r4=r3-r1 with r1=5 back-to-back -> SUB uses EX/MEM forwarded 12, result=7. Same case with MEM/WB also on r3=99 -> EX/MEM wins (7). With rd=0 on the producer -> no forwarding.
- MUL 0xFFFF_FFFF*3 -> stall high exactly 32 cycles, one bubble then valid_out=1 with result=0xFFFF_FFFD. Next instruction enters on the release edge.
- SRA 0x8000_0000 by 31 via alu_src=1 (sign_extend=31) -> 0xFFFF_FFFF. SLT -1 vs 1 -> 1. Op 13 -> 0.
- MUL started, flush at cycle 10 -> valid_out=0, stall=0 the next cycle, no product appears. reset_n pulsed mid-MUL -> all outputs 0 asynchronously.
- Store: SW with rt hazard from MEM/WB (data 0xA5A5_A5A5), alu_src=1 -> registro_2_out=0xA5A5_A5A5, result=address sum.
